// File: rtl/i2c_master_sda_seq.sv
// I2C master bit/byte sequencer: owns the bit/phase FSM, generates SCL and an
// open-drain SDA enable, samples slave ACKs and read data, bursts up to
// MAX_BYTES data bytes after the address and memory byte.
// Optional feature macro: I2C_RSTART_EN (repeated START before read data).
module i2c_master_sda_seq #(
    parameter int unsigned MAX_BYTES = 4,
    parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   sda_clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   rw,
    input  logic [6:0]             addr,
    input  logic [7:0]             mem,
    input  logic [CNT_W-1:0]       nbytes,
    input  logic [8*MAX_BYTES-1:0] wdata,
    output logic [8*MAX_BYTES-1:0] rdata,
    output logic                   busy,
    output logic                   done,
    output logic                   nack,
    output logic                   scl_o,
    output logic                   sda_oe,
    input  logic                   sda_i
);

`ifdef I2C_RSTART_EN
    localparam bit RstartEn = 1'b1;
`else
    localparam bit RstartEn = 1'b0;
`endif

    typedef enum logic [3:0] {
        StIdle, StStart, StAddr, StAckA, StMem, StAckM, StRstart, StData, StAckD, StStop
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             phase_q, phase_d;
    logic [2:0]             bit_q, bit_d;
    logic [CNT_W-1:0]       byte_q, byte_d;
    logic [CNT_W-1:0]       n_q, n_d;
    logic                   rw_q, rw_d;
    logic [6:0]             addr_q, addr_d;
    logic [7:0]             mem_q, mem_d;
    logic [8*MAX_BYTES-1:0] wdata_q, wdata_d;
    logic [8*MAX_BYTES-1:0] rdata_q, rdata_d;
    logic                   nack_q, nack_d;
    logic                   samp_q, samp_d;
    logic                   second_q, second_d;  // re-sent address after repeated START

    logic [CNT_W-1:0]       nbytes_clamped;
    logic                   last_byte;
    logic                   rw_bit;
    logic [7:0]             data_byte;
    logic [7:0]             tx_byte;
    logic                   tx_bit;

    assign nbytes_clamped = (nbytes > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : nbytes;
    assign last_byte      = (byte_q + CNT_W'(1)) == n_q;
    // With repeated START the first address phase is always a write.
    assign rw_bit         = RstartEn ? (rw_q & second_q) : rw_q;

    // Select the current write data byte.
    always_comb begin
        data_byte = 8'h00;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (byte_q == CNT_W'(b)) data_byte = wdata_q[8*b +: 8];
        end
    end

    // Pick the byte being shifted out and its current bit, MSB first.
    always_comb begin
        tx_byte = data_byte;
        if (state_q == StAddr) tx_byte = {addr_q, rw_bit};
        else if (state_q == StMem) tx_byte = mem_q;
        tx_bit = tx_byte[~bit_q];
    end

    // Next-state logic: phase/bit/byte sequencing, sampling and accept.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        n_d      = n_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        mem_d    = mem_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        nack_d   = nack_q;
        samp_d   = samp_q;
        second_d = second_q;
        if (state_q == StIdle) begin
            phase_d = 2'd0;
            bit_d   = 3'd0;
            if (start) begin
                rw_d     = rw;
                addr_d   = addr;
                mem_d    = mem;
                n_d      = nbytes_clamped;
                wdata_d  = wdata;
                rdata_d  = '0;
                nack_d   = 1'b0;
                byte_d   = '0;
                second_d = 1'b0;
                state_d  = StStart;
            end
        end else begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd2) begin
                samp_d = sda_i;
                if (state_q == StData && rw_q) begin
                    for (int b = 0; b < MAX_BYTES; b++) begin
                        if (byte_q == CNT_W'(b)) rdata_d[8*b +: 8] = {rdata_q[8*b +: 7], sda_i};
                    end
                end
            end
            if (phase_q == 2'd3) begin
                unique case (state_q)
                    StStart, StRstart: begin
                        bit_d   = 3'd0;
                        state_d = StAddr;
                    end
                    StAddr: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = StAckA;
                    end
                    StAckA: begin
                        if (samp_q) begin
                            nack_d  = 1'b1;
                            state_d = StStop;
                        end else if (second_q) begin
                            state_d = StData;
                        end else begin
                            state_d = StMem;
                        end
                    end
                    StMem: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = StAckM;
                    end
                    StAckM: begin
                        if (samp_q) begin
                            nack_d  = 1'b1;
                            state_d = StStop;
                        end else if (n_q == '0) begin
                            state_d = StStop;
                        end else if (RstartEn && rw_q) begin
                            second_d = 1'b1;
                            state_d  = StRstart;
                        end else begin
                            state_d = StData;
                        end
                    end
                    StData: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = StAckD;
                    end
                    StAckD: begin
                        if (!rw_q && samp_q) begin
                            nack_d  = 1'b1;
                            state_d = StStop;
                        end else begin
                            byte_d  = byte_q + CNT_W'(1);
                            state_d = last_byte ? StStop : StData;
                        end
                    end
                    StStop:  state_d = StIdle;
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    // State and datapath registers; reset releases the bus at once.
    always_ff @(posedge sda_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            phase_q  <= 2'd0;
            bit_q    <= 3'd0;
            byte_q   <= '0;
            n_q      <= '0;
            rw_q     <= 1'b0;
            addr_q   <= 7'd0;
            mem_q    <= 8'd0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            nack_q   <= 1'b0;
            samp_q   <= 1'b0;
            second_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            n_q      <= n_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            mem_q    <= mem_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            nack_q   <= nack_d;
            samp_q   <= samp_d;
            second_q <= second_d;
        end
    end

    // Bus waveform decode from the current state and phase.
    always_comb begin
        scl_o  = 1'b1;
        sda_oe = 1'b0;
        unique case (state_q)
            StIdle:   ;
            StStart:  sda_oe = phase_q[1];
            StRstart: begin
                scl_o  = (phase_q != 2'd0);
                sda_oe = phase_q[1];
            end
            StStop: begin
                scl_o  = (phase_q != 2'd0);
                sda_oe = (phase_q != 2'd3);
            end
            default: begin
                scl_o = phase_q[0] ^ phase_q[1];
                if (state_q == StAddr || state_q == StMem) sda_oe = ~tx_bit;
                else if (state_q == StData) sda_oe = rw_q ? 1'b0 : ~tx_bit;
                else if (state_q == StAckD) sda_oe = rw_q & ~last_byte;
            end
        endcase
    end

    assign busy  = (state_q != StIdle);
    assign done  = (state_q == StStop) && (phase_q == 2'd3);
    assign nack  = nack_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_i2c_master_sda_seq.sv
// Self-checking bench for i2c_master_sda_seq: a slot-level model of the
// transaction (master bits, slave bits, repeated START) yields the expected
// bus waveform per cycle, the final nack flag and the read data.
module tb_i2c_master_sda_seq;

    localparam int unsigned MAX_BYTES = 4;
    localparam int unsigned CNT_W     = $clog2(MAX_BYTES + 1);
`ifdef I2C_RSTART_EN
    localparam bit RSTART = 1'b1;
`else
    localparam bit RSTART = 1'b0;
`endif
    localparam logic [1:0] KM = 2'd0;  // master drives, value = expected sda_oe
    localparam logic [1:0] KS = 2'd1;  // slave drives, value = sda_i level
    localparam logic [1:0] KR = 2'd2;  // repeated START

    logic                   sda_clk = 1'b0;
    logic                   reset_n;
    logic                   start;
    logic                   rw;
    logic [6:0]             addr;
    logic [7:0]             mem;
    logic [CNT_W-1:0]       nbytes;
    logic [8*MAX_BYTES-1:0] wdata;
    logic [8*MAX_BYTES-1:0] rdata;
    logic                   busy, done, nack, scl_o, sda_oe, sda_i;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] sk_q[$];
    logic       sv_q[$];

    i2c_master_sda_seq #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
        .sda_clk(sda_clk), .reset_n(reset_n), .start(start), .rw(rw), .addr(addr),
        .mem(mem), .nbytes(nbytes), .wdata(wdata), .rdata(rdata), .busy(busy),
        .done(done), .nack(nack), .scl_o(scl_o), .sda_oe(sda_oe), .sda_i(sda_i)
    );

    always #5 sda_clk = ~sda_clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic push_slot(input logic [1:0] k, input logic v);
        sk_q.push_back(k);
        sv_q.push_back(v);
    endtask

    task automatic push_master_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) push_slot(KM, ~b[i]);
    endtask

    task automatic push_slave_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) push_slot(KS, b[i]);
    endtask

    // nack_at: 0 addr ack, 1 mem ack, 2 re-sent addr ack, 3+k data byte k ack.
    // pulse_t: cycle to pulse start while busy (-1 none); rst_t: cycle to reset.
    task automatic run_txn(input logic t_rw, input logic [6:0] t_addr, input logic [7:0] t_mem,
                           input logic [CNT_W-1:0] t_nb, input logic [31:0] t_wd,
                           input logic [31:0] t_rd, input int nack_at, input int pulse_t,
                           input int rst_t);
        int   n, total;
        bit   ab;
        logic [31:0] rdata_exp;
        sk_q.delete();
        sv_q.delete();
        n         = (int'(t_nb) > int'(MAX_BYTES)) ? int'(MAX_BYTES) : int'(t_nb);
        rdata_exp = '0;
        ab        = 1'b0;
        push_master_byte({t_addr, RSTART ? 1'b0 : t_rw});
        push_slot(KS, nack_at == 0);
        ab = (nack_at == 0);
        if (!ab) begin
            push_master_byte(t_mem);
            push_slot(KS, nack_at == 1);
            ab = (nack_at == 1);
        end
        if (!ab && RSTART && t_rw && n != 0) begin
            push_slot(KR, 1'b0);
            push_master_byte({t_addr, 1'b1});
            push_slot(KS, nack_at == 2);
            ab = (nack_at == 2);
        end
        for (int k = 0; k < n; k++) begin
            if (!ab) begin
                if (t_rw) begin
                    push_slave_byte(t_rd[8*k +: 8]);
                    push_slot(KM, k != n - 1);
                    rdata_exp[8*k +: 8] = t_rd[8*k +: 8];
                end else begin
                    push_master_byte(t_wd[8*k +: 8]);
                    push_slot(KS, nack_at == 3 + k);
                    ab = (nack_at == 3 + k);
                end
            end
        end
        total = 8 + 4 * sk_q.size();

        start = 1'b1; rw = t_rw; addr = t_addr; mem = t_mem; nbytes = t_nb; wdata = t_wd;
        @(posedge sda_clk); #1;
        start = 1'b0;
        // Change the inputs after accept; the bus must still follow the latched values.
        rw = 1'($urandom); addr = 7'($urandom); mem = 8'($urandom);
        nbytes = CNT_W'($urandom); wdata = $urandom;
        for (int t = 0; t <= total; t++) begin
            int         p, j;
            logic [3:0] exp_v;
            logic       e_scl, e_oe;
            p = t % 4;
            sda_i = 1'b1;
            e_scl = 1'b1;
            e_oe  = 1'b0;
            if (t < 4) begin
                e_oe = (p >= 2);
            end else if (t >= total - 4) begin
                e_scl = (p != 0);
                e_oe  = (p != 3);
            end else begin
                j = (t - 4) / 4;
                if (sk_q[j] == KR) begin
                    e_scl = (p != 0);
                    e_oe  = (p >= 2);
                end else begin
                    e_scl = (p == 1 || p == 2);
                    if (sk_q[j] == KM) e_oe = sv_q[j];
                    else sda_i = sv_q[j];
                end
            end
            exp_v = (t == total) ? 4'b0010 : {1'b1, t == total - 1, e_scl, e_oe};
            start = (t == pulse_t);
            @(negedge sda_clk);
            if (t == rst_t) begin
                reset_n = 1'b0;
                #1;
                check_val("rst_bus", {busy, done, scl_o, sda_oe}, 4'b0010);
                check_val("rst_nack", nack, 0);
                @(negedge sda_clk);
                reset_n = 1'b1;
                start   = 1'b0;
                sda_i   = 1'b1;
                repeat (2) @(posedge sda_clk);
                #1;
                return;
            end
            check_val("bus", {busy, done, scl_o, sda_oe}, exp_v);
            if (t == 0) check_val("nack_clr", nack, 0);
            @(posedge sda_clk); #1;
        end
        start = 1'b0;
        check_val("nack", nack, ab);
        check_val("rdata", rdata, rdata_exp);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; mem = '0; nbytes = '0;
        wdata = '0; sda_i = 1'b1;
        repeat (2) @(negedge sda_clk);
        check_val("reset_bus", {busy, done, scl_o, sda_oe}, 4'b0010);
        check_val("reset_nack", nack, 0);
        check_val("reset_rdata", rdata, 0);
        reset_n = 1'b1;
        @(posedge sda_clk); #1;

        // Directed cases.
        run_txn(1'b0, 7'h50, 8'h10, 3'd2, 32'h0000A55A, 32'h0, -1, -1, -1);
        run_txn(1'b1, 7'h50, 8'h00, 3'd3, 32'h0, 32'h00332211, -1, -1, -1);
        run_txn(1'b0, 7'h50, 8'h10, 3'd2, 32'h12345678, 32'h0, 0, -1, -1);
        repeat (3) @(posedge sda_clk);
        #1;
        check_val("nack_hold", nack, 1);
        @(negedge sda_clk);
        reset_n = 1'b0;
        #1;
        check_val("idle_rst_nack", nack, 0);
        @(negedge sda_clk);
        reset_n = 1'b1;
        @(posedge sda_clk); #1;
        run_txn(1'b0, 7'h2A, 8'hC3, 3'd7, 32'hDEADBEEF, 32'h0, -1, -1, -1);
        run_txn(1'b1, 7'h11, 8'h22, 3'd7, 32'h0, 32'hCAFEF00D, -1, 33, -1);
        run_txn(1'b0, 7'h3C, 8'h5A, 3'd0, 32'hFFFFFFFF, 32'h0, -1, 50, -1);
        run_txn(1'b0, 7'h33, 8'h44, 3'd2, 32'h0000F00F, 32'h0, 4, -1, -1);
        run_txn(1'b0, 7'h50, 8'h10, 3'd4, 32'h89ABCDEF, 32'h0, -1, -1, 82);
        run_txn(1'b1, 7'h07, 8'h99, 3'd1, 32'h0, 32'h000000A5, -1, -1, -1);

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            logic r_rw;
            int   r_nack, r_pulse;
            r_rw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 6) r_nack = -1;
            else r_nack = r_rw ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 6));
            r_pulse = $urandom_range(0, 1) ? int'($urandom_range(1, 40)) : -1;
            run_txn(r_rw, 7'($urandom), 8'($urandom), CNT_W'($urandom_range(0, 7)),
                    $urandom, $urandom, r_nack, r_pulse, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
